lsu_ctrl: RTL and testbench
===========================

LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 255, SHALL set the maximum number of cycles spent in REQ+WAIT before an abort.
REQ-002 clk  in  1  system clock; all state SHALL update on its rising edge.
REQ-003 rst  in  1  reset, asynchronous and active-low.
REQ-004 in_valid  in  1 / in_ready  out  1  upstream (execute) handshake.
REQ-005 addr  in  32 / wdata  in  32  byte address and store data.
REQ-006 is_load, is_store  in  3 each  op codes: 000 byte, 001 half, 010 word, 100 byte-unsigned, 101 half-unsigned (load only); 111 = none.
REQ-007 mem_req  out  1 / mem_gnt  in  1  memory request handshake.
REQ-008 mem_we  out  1 / mem_addr  out  32 (bits[1:0]=00) / mem_wdata  out  32 / mem_wmask  out  4  memory command.
REQ-009 mem_rvalid  in  1 / mem_rdata  in  32  memory response; acts as the write-acknowledge for stores.
REQ-010 out_valid  out  1 / out_ready  in  1 / out_rdata  out  32 / out_err  out  1  downstream (writeback) result.

Function
REQ-011 The FSM SHALL have the states IDLE, REQ, WAIT and RESP; in_ready SHALL be 1 only in IDLE.
REQ-012 On in_valid&in_ready, the block SHALL capture addr, wdata, is_load and is_store into registers.
- Misaligned op (half with addr[0]=1; word with addr[1:0]!=0): go to RESP with err=1.
- Both ops !=111: go to RESP with err=1.
- Both ops =111: go to RESP with err=0, rdata=0.
- Otherwise: go to REQ.
REQ-013 In REQ, mem_req SHALL be held at 1 with stable command outputs until mem_gnt=1, then the FSM SHALL move to WAIT; mem_req SHALL be 0 in all other states.
REQ-014 mem_addr SHALL be {addr[31:2],2'b00}; mem_we SHALL be 1 for stores.
REQ-015 Store mask: SB = 0001<<addr[1:0]; SH = 0011<<addr[1:0]; SW = 1111.
REQ-016 Store data: mem_wdata SHALL be wdata replicated (byte x4, half x2, word as-is) so that the masked lanes carry the data.
REQ-017 In WAIT, mem_rvalid=1 SHALL latch the result and move to RESP; mem_rvalid outside WAIT SHALL be ignored.
REQ-018 Load extraction: select byte mem_rdata[8*addr[1:0]+:8] or half mem_rdata[16*addr[1]+:16]; sign-extend for 000/001, zero-extend for 100/101, pass the word for 010.
- Stores SHALL return rdata=0.
REQ-019 Timeout counter: clear on entering REQ, increment each cycle in REQ or WAIT. On reaching TIMEOUT, go to RESP with err=1 and rdata=0, dropping mem_req.
REQ-020 In RESP, out_valid=1 and out_rdata/out_err SHALL be stable until out_ready=1; the FSM SHALL then return to IDLE.
- A new request SHALL be accepted no earlier than the following cycle, giving one transaction in flight.
REQ-021 Minimum latency, with gnt in the first REQ cycle and rvalid the cycle after: accept at T, mem_req at T+1, rvalid at T+2, out_valid at T+3.
- The fast path (misaligned or no-op) SHALL give out_valid at T+1.
REQ-022 A mem_gnt arriving in the same cycle as the timeout SHALL take priority (move to WAIT); the count continues in WAIT.

Reset
REQ-023 While rst=0, the block SHALL hold: state=IDLE, in_ready=1, mem_req=0, mem_we=0, mem_wmask=0, mem_addr=0, mem_wdata=0, out_valid=0, out_rdata=0, out_err=0, counter=0, captured registers=0 with ops=111.
REQ-024 Reset asserted mid-transaction SHALL abandon the transaction immediately with no response; the first cycle after deassertion SHALL be IDLE.

Structure
REQ-025 A shared package SHALL hold the op-code localparams (LB/LH/LW/LBU/LHU, SB/SH/SW, OP_NONE=3'b111), the FSM state enum, and the TIMEOUT default.
REQ-026 Load extraction and extension SHALL live in one combinational sub-module, lsu_load_align (rdata, addr_lsb, op -> result).
- Mask and data replication SHALL stay inline.

Verification
REQ-027 LW addr=0x8000_0004, mem_rdata=0xDEADBEEF, gnt immediate, rvalid +1 -> out_valid at T+3, out_rdata=0xDEADBEEF, err=0, mem_addr=0x8000_0004.
REQ-028 LB addr=0x8000_0003, mem_rdata=0x80FF_1234 -> out_rdata=0xFFFF_FF80.
- LBU at the same address -> 0x0000_0080.
- LH addr=0x..02 -> 0xFFFF_80FF.
REQ-029 SH addr=0x8000_0002, wdata=0x0000_ABCD -> mem_wmask=1100, mem_wdata=0xABCD_ABCD, mem_we=1; after rvalid, out_rdata=0, err=0.
REQ-030 LW addr=0x8000_0001 -> no mem_req ever, out_valid at T+1, out_err=1.
- Both ops !=111 -> out_err=1.
REQ-031 mem_gnt held 0, TIMEOUT=4 -> mem_req drops after 4 cycles, out_err=1.
- A late mem_rvalid in IDLE SHALL be ignored, and the next LW SHALL complete normally.
REQ-032 out_ready held 0 for 5 cycles -> out_valid, out_rdata and in_ready=0 stable.
- rst pulsed low during WAIT -> all outputs return to reset values asynchronously, with no out_valid afterwards.

Source files
------------

// File: rtl/lsu_ctrl_pkg.sv
// Shared op codes, FSM state type and timeout default for the load/store unit.
// Latency: n/a (declarations and a pure combinational helper only).
// Backpressure: n/a.
package lsu_ctrl_pkg;

    localparam int TIMEOUT_DEFAULT = 255;

    // Load op codes
    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;

    // Store op codes
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    localparam logic [2:0] OP_NONE = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    // Flags an op that cannot be sent to memory: misaligned for its size,
    // an unsigned variant used as a store, or an unassigned code.
    function automatic logic op_bad(input logic [2:0] op, input logic [1:0] lsb,
                                    input logic is_st);
        logic bad;
        bad = 1'b0;
        case (op)
            LB:      bad = 1'b0;
            LH:      bad = lsb[0];
            LW:      bad = |lsb;
            LBU:     bad = is_st;
            LHU:     bad = is_st | lsb[0];
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Selects the addressed byte/half/word of a load response and sign/zero extends it.
// Latency: purely combinational.
// Backpressure: none (no handshake).
module lsu_load_align
    import lsu_ctrl_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lsb,
    input  logic [2:0]  op,
    output logic [31:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane select followed by extension chosen by the load op
    always_comb begin
        byte_sel = rdata[{addr_lsb, 3'b000} +: 8];
        half_sel = rdata[{addr_lsb[1], 4'b0000} +: 16];
        case (op)
            LB:      result = {{24{byte_sel[7]}}, byte_sel};
            LBU:     result = {24'd0, byte_sel};
            LH:      result = {{16{half_sel[15]}}, half_sel};
            LHU:     result = {16'd0, half_sel};
            LW:      result = rdata;
            default: result = 32'd0;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Single-outstanding load/store controller between execute, memory and writeback.
// Latency: 3 cycles accept-to-result with immediate grant/response; 1 cycle for rejected or no-op requests.
// Backpressure: in_ready only in IDLE; result held in RESP until out_ready; mem command held until mem_gnt or timeout.
module lsu_ctrl
    import lsu_ctrl_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [2:0]  is_load,
    input  logic [2:0]  is_store,
    output logic        mem_req,
    input  logic        mem_gnt,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_rdata,
    output logic        out_err
);

    localparam int CW = $clog2(TIMEOUT + 1);
    // Count value seen in the last allowed REQ/WAIT cycle
    localparam logic [CW-1:0] CNT_LIMIT = CW'(TIMEOUT - 1);

    state_t        state;
    logic [31:0]   addr_q;
    logic [31:0]   wdata_q;
    logic [2:0]    ld_q;
    logic [2:0]    st_q;
    logic [CW-1:0] cnt;
    logic [31:0]   rdata_q;
    logic          err_q;

    logic          in_fast;
    logic          in_fast_err;
    logic [31:0]   load_res;

    lsu_load_align u_load_align (
        .rdata    (mem_rdata),
        .addr_lsb (addr_q[1:0]),
        .op       (ld_q),
        .result   (load_res)
    );

    // Classify the incoming request: anything that never reaches memory answers in one cycle
    always_comb begin
        in_fast     = 1'b1;
        in_fast_err = 1'b1;
        if (is_load == OP_NONE && is_store == OP_NONE) begin
            in_fast_err = 1'b0;
        end else if (is_load != OP_NONE && is_store != OP_NONE) begin
            in_fast_err = 1'b1;
        end else if (is_load != OP_NONE) begin
            in_fast = op_bad(is_load, addr[1:0], 1'b0);
        end else begin
            in_fast = op_bad(is_store, addr[1:0], 1'b1);
        end
    end

    // Transaction FSM with capture, timeout count and result registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_IDLE;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            ld_q    <= OP_NONE;
            st_q    <= OP_NONE;
            cnt     <= '0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        addr_q  <= addr;
                        wdata_q <= wdata;
                        ld_q    <= is_load;
                        st_q    <= is_store;
                        if (in_fast) begin
                            state   <= ST_RESP;
                            err_q   <= in_fast_err;
                            rdata_q <= 32'd0;
                        end else begin
                            state <= ST_REQ;
                            cnt   <= '0;
                        end
                    end
                end
                ST_REQ: begin
                    // A grant in the final allowed cycle still wins over the abort
                    if (mem_gnt) begin
                        state <= ST_WAIT;
                        cnt   <= cnt + 1'b1;
                    end else if (cnt >= CNT_LIMIT) begin
                        state   <= ST_RESP;
                        err_q   <= 1'b1;
                        rdata_q <= 32'd0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (mem_rvalid) begin
                        state   <= ST_RESP;
                        err_q   <= 1'b0;
                        rdata_q <= (st_q != OP_NONE) ? 32'd0 : load_res;
                    end else if (cnt >= CNT_LIMIT) begin
                        state   <= ST_RESP;
                        err_q   <= 1'b1;
                        rdata_q <= 32'd0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_RESP: begin
                    if (out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = (state == ST_IDLE);
    assign mem_req   = (state == ST_REQ);
    assign out_valid = (state == ST_RESP);
    assign out_rdata = rdata_q;
    assign out_err   = err_q;

    // Memory command, driven only while requesting so it is quiet otherwise
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = 32'd0;
        mem_wdata = 32'd0;
        mem_wmask = 4'b0000;
        if (state == ST_REQ) begin
            mem_addr = {addr_q[31:2], 2'b00};
            if (st_q != OP_NONE) begin
                mem_we = 1'b1;
                case (st_q)
                    SB: begin
                        mem_wmask = 4'b0001 << addr_q[1:0];
                        mem_wdata = {4{wdata_q[7:0]}};
                    end
                    SH: begin
                        mem_wmask = 4'b0011 << addr_q[1:0];
                        mem_wdata = {2{wdata_q[15:0]}};
                    end
                    SW: begin
                        mem_wmask = 4'b1111;
                        mem_wdata = wdata_q;
                    end
                    default: begin
                        mem_wmask = 4'b0000;
                        mem_wdata = 32'd0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: directed cases plus randomized transactions vs. a phase-level model.
// Latency: n/a.
// Backpressure: exercises out_ready stalls, slow grants/responses and timeouts.
module tb_lsu_ctrl;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  is_load;
    logic [2:0]  is_store;
    logic        mem_req;
    logic        mem_gnt;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_rdata;
    logic        out_err;

    int n_chk  = 0;
    int n_pass = 0;

    // Per-cycle expectations written by the stimulus process
    logic        chk_en = 1'b0;
    logic        e_in_ready, e_mem_req, e_out_valid;
    logic        e_we, e_st, e_err, e_rd_chk;
    logic [31:0] e_addr, e_wdata, e_rdata;
    logic [3:0]  e_mask;

    logic [2:0] ld_ops [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    logic [2:0] st_ops [3] = '{3'b000, 3'b001, 3'b010};

    lsu_ctrl #(.TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .addr       (addr),
        .wdata      (wdata),
        .is_load    (is_load),
        .is_store   (is_store),
        .mem_req    (mem_req),
        .mem_gnt    (mem_gnt),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wmask  (mem_wmask),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_rdata  (out_rdata),
        .out_err    (out_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %08h want %08h at %0t", name, act, exp, $time);
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
    endtask

    // Load result from the byte/half/word rules using plain shifts and masks
    function automatic logic [31:0] exp_load(input logic [2:0] op, input logic [1:0] lsb,
                                             input logic [31:0] rd);
        logic [31:0] v;
        case (op)
            3'b000, 3'b100: begin
                v = (rd >> (8 * lsb)) & 32'hFF;
                if (op == 3'b000 && v >= 32'h80) v = v | 32'hFFFF_FF00;
            end
            3'b001, 3'b101: begin
                v = (rd >> (16 * lsb[1])) & 32'hFFFF;
                if (op == 3'b001 && v >= 32'h8000) v = v | 32'hFFFF_0000;
            end
            default: v = rd;
        endcase
        return v;
    endfunction

    // Compare process: every cycle, DUT outputs against the current expectations
    always @(negedge clk) begin
        if (chk_en) begin
            check1("in_ready", in_ready, e_in_ready);
            check1("mem_req", mem_req, e_mem_req);
            check1("out_valid", out_valid, e_out_valid);
            if (e_mem_req) begin
                check1("mem_we", mem_we, e_we);
                check("mem_addr", mem_addr, e_addr);
                if (e_st) begin
                    check("mem_wmask", {28'd0, mem_wmask}, {28'd0, e_mask});
                    check("mem_wdata", mem_wdata, e_wdata);
                end
            end
            if (e_out_valid) begin
                check1("out_err", out_err, e_err);
                if (e_rd_chk) check("out_rdata", out_rdata, e_rdata);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_phase(input logic ir, input logic mr, input logic ov);
        e_in_ready  = ir;
        e_mem_req   = mr;
        e_out_valid = ov;
    endtask

    task automatic check_reset_outputs();
        check1("rst_in_ready", in_ready, 1'b1);
        check1("rst_mem_req", mem_req, 1'b0);
        check1("rst_mem_we", mem_we, 1'b0);
        check("rst_mem_wmask", {28'd0, mem_wmask}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check1("rst_out_valid", out_valid, 1'b0);
        check("rst_out_rdata", out_rdata, 32'd0);
        check1("rst_out_err", out_err, 1'b0);
    endtask

    task automatic idle_cycles(input int n, input logic stray);
        for (int i = 0; i < n; i++) begin
            exp_phase(1'b1, 1'b0, 1'b0);
            mem_rvalid = stray ? 1'($urandom_range(0, 1)) : 1'b0;
            mem_gnt    = stray ? 1'($urandom_range(0, 1)) : 1'b0;
            mem_rdata  = $urandom;
            tick();
        end
        mem_rvalid = 1'b0;
        mem_gnt    = 1'b0;
    endtask

    // One transaction: g = REQ cycles before grant, r = WAIT cycles before response,
    // hold = cycles out_ready stays low; optional literal pin on the result.
    task automatic run_txn(input logic [2:0] ld, input logic [2:0] st, input logic [31:0] a,
                           input logic [31:0] wd, input logic [31:0] rd, input int g,
                           input int r, input int hold, input logic pin_en,
                           input logic [31:0] pin_rdata, input logic pin_err);
        logic        ld_none, st_none, fast, t_out, res_err;
        logic [2:0]  op;
        logic [31:0] res;
        int          nbytes, limit;
        ld_none = (ld == 3'b111);
        st_none = (st == 3'b111);
        fast    = 1'b0;
        t_out   = 1'b0;
        res     = 32'd0;
        res_err = 1'b0;
        nbytes  = 4;
        if (ld_none && st_none) begin
            fast = 1'b1;
        end else if (!ld_none && !st_none) begin
            fast = 1'b1;
            res_err = 1'b1;
        end else begin
            op = ld_none ? st : ld;
            nbytes = (op[1:0] == 2'b00) ? 1 : (op[1:0] == 2'b01) ? 2 : 4;
            if ((int'(a[1:0]) % nbytes) != 0) begin
                fast = 1'b1;
                res_err = 1'b1;
            end
        end
        e_addr = a & 32'hFFFF_FFFC;
        e_we   = !st_none;
        e_st   = !st_none;
        e_mask = 4'((nbytes == 4) ? 15 : ((nbytes == 2 ? 3 : 1) << int'(a[1:0])));
        if (nbytes == 1)      e_wdata = (wd & 32'hFF) * 32'h0101_0101;
        else if (nbytes == 2) e_wdata = (wd & 32'hFFFF) * 32'h0001_0001;
        else                  e_wdata = wd;

        // accept
        in_valid = 1'b1; addr = a; wdata = wd; is_load = ld; is_store = st;
        exp_phase(1'b1, 1'b0, 1'b0);
        tick();
        in_valid = 1'b0; addr = $urandom; wdata = $urandom;
        is_load = 3'($urandom); is_store = 3'($urandom);

        if (!fast) begin
            for (int k = 0; k < 1000; k++) begin
                exp_phase(1'b0, 1'b1, 1'b0);
                mem_gnt    = (k == g);
                mem_rvalid = 1'($urandom_range(0, 1));
                mem_rdata  = $urandom;
                tick();
                mem_gnt = 1'b0; mem_rvalid = 1'b0;
                if (k == g) break;
                if (k == TO - 1) begin t_out = 1'b1; break; end
            end
            if (!t_out) begin
                limit = (TO - 1 > g + 1) ? TO - 1 : g + 1;
                for (int idx = g + 1; idx < 1000; idx++) begin
                    exp_phase(1'b0, 1'b0, 1'b0);
                    mem_rvalid = (idx - (g + 1) == r);
                    mem_rdata  = mem_rvalid ? rd : $urandom;
                    mem_gnt    = 1'($urandom_range(0, 1));
                    tick();
                    mem_rvalid = 1'b0; mem_gnt = 1'b0;
                    if (idx - (g + 1) == r) break;
                    if (idx >= limit) begin t_out = 1'b1; break; end
                end
            end
            if (t_out) begin res = 32'd0; res_err = 1'b1; end
            else if (!ld_none) res = exp_load(ld, a[1:0], rd);
            else res = 32'd0;
        end

        e_rdata  = res;
        e_err    = res_err;
        e_rd_chk = !(fast && res_err);
        for (int h = 0; h <= hold; h++) begin
            exp_phase(1'b0, 1'b0, 1'b1);
            out_ready  = (h == hold);
            in_valid   = (h == hold) ? 1'b0 : 1'($urandom_range(0, 1));
            mem_rvalid = 1'($urandom_range(0, 1));
            if (h == 0 && pin_en) begin
                #2;
                check1("pin_err", out_err, pin_err);
                if (!pin_err) check("pin_rdata", out_rdata, pin_rdata);
            end
            tick();
            out_ready = 1'b0; in_valid = 1'b0; mem_rvalid = 1'b0;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a, wd, rd;
        logic [2:0]  ld, st, op;
        int          kind, g;
        rst = 1'b0; in_valid = 1'b0; addr = 32'd0; wdata = 32'd0;
        is_load = 3'b111; is_store = 3'b111; mem_gnt = 1'b0; mem_rvalid = 1'b0;
        mem_rdata = 32'd0; out_ready = 1'b0;
        e_we = 1'b0; e_st = 1'b0; e_err = 1'b0; e_rd_chk = 1'b0;
        e_addr = 32'd0; e_wdata = 32'd0; e_rdata = 32'd0; e_mask = 4'd0;
        exp_phase(1'b1, 1'b0, 1'b0);

        #2;
        check_reset_outputs();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        chk_en = 1'b1;
        idle_cycles(2, 1'b0);

        // directed cases with literal pins
        run_txn(3'b010, 3'b111, 32'h8000_0004, 32'd0, 32'hDEAD_BEEF, 0, 0, 0, 1'b1, 32'hDEAD_BEEF, 1'b0);
        run_txn(3'b000, 3'b111, 32'h8000_0003, 32'd0, 32'h80FF_1234, 0, 0, 0, 1'b1, 32'hFFFF_FF80, 1'b0);
        run_txn(3'b100, 3'b111, 32'h8000_0003, 32'd0, 32'h80FF_1234, 0, 0, 0, 1'b1, 32'h0000_0080, 1'b0);
        run_txn(3'b001, 3'b111, 32'h8000_0002, 32'd0, 32'h80FF_1234, 0, 0, 0, 1'b1, 32'hFFFF_80FF, 1'b0);
        run_txn(3'b111, 3'b001, 32'h8000_0002, 32'h0000_ABCD, 32'h1234_5678, 0, 0, 0, 1'b1, 32'd0, 1'b0);
        run_txn(3'b010, 3'b111, 32'h8000_0001, 32'd0, 32'd0, 0, 0, 0, 1'b1, 32'd0, 1'b1);
        run_txn(3'b000, 3'b010, 32'h8000_0000, 32'd0, 32'd0, 0, 0, 0, 1'b1, 32'd0, 1'b1);
        run_txn(3'b111, 3'b111, 32'h8000_0000, 32'd0, 32'd0, 0, 0, 0, 1'b1, 32'd0, 1'b0);
        run_txn(3'b010, 3'b111, 32'h0000_0100, 32'd0, 32'h1111_2222, 0, 1, 5, 1'b1, 32'h1111_2222, 1'b0);
        run_txn(3'b010, 3'b111, 32'h0000_0200, 32'd0, 32'h3333_4444, 100, 0, 0, 1'b1, 32'd0, 1'b1);
        idle_cycles(3, 1'b1);
        run_txn(3'b010, 3'b111, 32'h0000_0300, 32'd0, 32'h5555_6666, 0, 0, 0, 1'b1, 32'h5555_6666, 1'b0);
        run_txn(3'b010, 3'b111, 32'h0000_0400, 32'd0, 32'h7777_8888, TO - 1, 0, 0, 1'b1, 32'h7777_8888, 1'b0);
        run_txn(3'b010, 3'b111, 32'h0000_0500, 32'd0, 32'h9999_AAAA, TO - 1, 1, 0, 1'b1, 32'd0, 1'b1);
        run_txn(3'b010, 3'b111, 32'h0000_0600, 32'd0, 32'hBBBB_CCCC, 1, 3, 0, 1'b1, 32'd0, 1'b1);

        // randomized transactions
        for (int t = 0; t < 80; t++) begin
            kind = $urandom_range(0, 9);
            a = $urandom; wd = $urandom; rd = $urandom;
            ld = 3'b111; st = 3'b111;
            if (kind == 1) begin
                ld = ld_ops[$urandom_range(0, 4)];
                st = st_ops[$urandom_range(0, 2)];
            end else if (kind >= 2) begin
                if ($urandom_range(0, 1) == 1) ld = ld_ops[$urandom_range(0, 4)];
                else st = st_ops[$urandom_range(0, 2)];
                op = (ld != 3'b111) ? ld : st;
                if (kind >= 4) begin
                    if (op[1:0] == 2'b01) a[0] = 1'b0;
                    else if (op[1:0] == 2'b10) a[1:0] = 2'b00;
                end
            end
            g = ($urandom_range(0, 9) < 8) ? int'($urandom_range(0, 2)) : int'($urandom_range(3, 6));
            run_txn(ld, st, a, wd, rd, g, int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 3)), 1'b0, 32'd0, 1'b0);
            idle_cycles(int'($urandom_range(0, 2)), 1'b1);
        end

        // reset pulled while waiting for the memory response
        in_valid = 1'b1; addr = 32'h0000_1000; is_load = 3'b010; is_store = 3'b111;
        exp_phase(1'b1, 1'b0, 1'b0);
        tick();
        in_valid = 1'b0;
        e_addr = 32'h0000_1000; e_we = 1'b0; e_st = 1'b0;
        exp_phase(1'b0, 1'b1, 1'b0);
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        exp_phase(1'b0, 1'b0, 1'b0);
        #1;
        chk_en = 1'b0;
        rst = 1'b0;
        #1;
        check_reset_outputs();
        mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D;
        tick();
        mem_rvalid = 1'b0;
        check_reset_outputs();
        rst = 1'b1;
        chk_en = 1'b1;
        idle_cycles(3, 1'b0);
        run_txn(3'b010, 3'b111, 32'h0000_2000, 32'd0, 32'h0BAD_F00D, 0, 0, 0, 1'b1, 32'h0BAD_F00D, 1'b0);
        idle_cycles(1, 1'b0);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
